dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
Controller for the direct-mapped data cache, 4 x 32-bit words per line, write-through, no write-allocate. Accepts one CPU load/store at a time and does tag lookup, refills lines from memory over a word-serial handshake, and forwards stores to memory. It drives the four words of the addressed line and the word offset straight into the downstream 4:1 word-select mux (w3→d, w2→c, w1→b, w0→a, word_sel→sel). The mux output is the CPU load data.

Parameters:
INDEX_W, 4, index bits; number of lines = 2**INDEX_W.
ADDR_W, 32, byte-address width; tag width = ADDR_W-4-INDEX_W.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
cpu_req  in  1  request valid; held until cpu_ready
cpu_we  in  1  1=store, 0=load
cpu_addr  in  ADDR_W  byte address; [1:0] ignored, [3:2] word, [3+INDEX_W:4] index, rest tag
cpu_wdata  in  32  store data
cpu_ready  out  1  one-cycle completion pulse
hit  out  1  lookup result, valid in COMPARE cycle
line_w3..line_w0  out  32 each  words of latched-index line, to mux d..a
word_sel  out  2  latched cpu_addr[3:2], to mux sel
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1=write word
mem_addr  out  ADDR_W  word-aligned memory address
mem_wdata  out  32  store data to memory
mem_rdata  in  32  refill data, valid with mem_ack
mem_ack  in  1  one-cycle acknowledge

Behaviour:
- States: IDLE, COMPARE, REFILL, WRITE_MEM, RESPOND.
- Reset (async, any state): state=IDLE. All valid bits=0. cpu_ready, hit, mem_req, mem_we=0. mem_addr, mem_wdata, word_sel, latched addr/data=0. Data and tag arrays are not reset.
- IDLE: on cpu_req=1, latch cpu_we, cpu_addr, cpu_wdata, then go to COMPARE. cpu_req is ignored in every other state.
- COMPARE (1 cycle): hit = valid[idx] & (tag[idx]==ltag).
  - Load hit → RESPOND.
  - Load miss → REFILL with k=0.
  - Store hit → write latched word into data[idx][word], then WRITE_MEM.
  - Store miss → WRITE_MEM, no line change.
- REFILL:
  - mem_req=1, mem_we=0, mem_addr={ltag,idx,k,2'b00}.
  - On mem_ack: data[idx][k]=mem_rdata, k++. mem_req stays high and the next address appears the following cycle.
  - On the ack with k=3: tag[idx]=ltag, valid[idx]=1, then RESPOND.
  - valid[idx] is cleared on entry, so a reset or abort mid-refill leaves the line invalid.
- WRITE_MEM: mem_req=1, mem_we=1, mem_addr={latched addr[31:2],2'b00}, mem_wdata=latched data. On mem_ack → RESPOND.
- RESPOND: cpu_ready=1 for exactly one cycle, then IDLE. The earliest next acceptance is the cycle after RESPOND.
- line_w*/word_sel reflect data[idx] continuously. They are guaranteed correct during the cpu_ready cycle of a load and include refilled words.
- Latency from cpu_req sampled:
  - Load hit: cpu_ready at cycle +2.
  - Load miss: 2 + 4 acks + ack waits.
  - Store: 2 + ack wait.
- mem_ack while mem_req=0 is ignored.
- Boundaries:
  - Index 2**INDEX_W-1 is handled like any other line.
  - Tag match with valid=0 is a miss.
  - Store miss never allocates.
  - A store hit updates the cache before the memory ack.

Decomposition:
- dcache_pkg: state enum; localparams WORD_LSB=2, INDEX_LSB=4, WORDS_PER_LINE=4; field-extract functions for tag/index/word.
- Sub-module dcache_tag_store: valid+tag arrays with async valid clear, tag write port, combinational hit compare.
- Data array stays in dcache_ctrl.

Test Plan:
- Reset, then load 0x0000_0010 with mem returning 0xA0..0xA3 for words 0..3 → four mem reads at 0x10, 0x14, 0x18, 0x1C; cpu_ready pulse; line_w0..3=0xA0..0xA3; word_sel=0.
- Repeat load 0x0000_001C → hit=1, no mem_req, cpu_ready at cycle +2, word_sel=3, mux out 0xA3.
- Store 0xDEADBEEF to 0x0000_0018 (hit) → mem write at 0x18 with that data; a following load of 0x18 hits and returns 0xDEADBEEF.
- Store to 0x0000_1010 (same index, different tag) → mem write only. A load of 0x10 still hits old line; a load of 0x1010 misses and refills.
- Assert rst_n=0 after 2nd refill ack of 0x0000_0020, then load 0x20 → miss, full 4-word refill, cpu_ready.
- Hold mem_ack low 5 cycles per word on refill → mem_addr stable while waiting; exactly 4 data writes; single cpu_ready pulse.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the direct-mapped, write-through data cache.
// Lines are four 32-bit words; the index sits directly above the word offset.
package dcache_pkg;

  localparam int unsigned WORD_LSB       = 2;
  localparam int unsigned INDEX_LSB      = 4;
  localparam int unsigned WORDS_PER_LINE = 4;
  localparam int unsigned MAX_ADDR_W     = 64;

  typedef enum logic [2:0] {
    StIdle,
    StCompare,
    StRefill,
    StWriteMem,
    StRespond
  } dc_state_e;

  function automatic logic [1:0] addr_word(input logic [MAX_ADDR_W-1:0] addr);
    return addr[WORD_LSB +: 2];
  endfunction

  function automatic logic [MAX_ADDR_W-1:0] addr_index(input logic [MAX_ADDR_W-1:0] addr,
                                                       input int unsigned index_w);
    return (addr >> INDEX_LSB) & ((64'd1 << index_w) - 64'd1);
  endfunction

  function automatic logic [MAX_ADDR_W-1:0] addr_tag(input logic [MAX_ADDR_W-1:0] addr,
                                                     input int unsigned index_w);
    return addr >> (INDEX_LSB + index_w);
  endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// CPU-side, memory-side and line-mux signals of the data cache controller.
// slave is the controller's view; master is the view of whoever surrounds it.
interface dcache_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic              cpu_ready;
  logic              hit;
  logic [31:0]       line_w3;
  logic [31:0]       line_w2;
  logic [31:0]       line_w1;
  logic [31:0]       line_w0;
  logic [1:0]        word_sel;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    output cpu_ready, hit, line_w3, line_w2, line_w1, line_w0, word_sel,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    input  cpu_ready, hit, line_w3, line_w2, line_w1, line_w0, word_sel,
           mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/dcache_tag_store.sv
// Valid bits and tags for every line, with a combinational hit compare on the selected index.
// Only the valid bits are reset; tags are meaningless while their line is invalid.
module dcache_tag_store #(
  parameter int unsigned INDEX_W = 4,
  parameter int unsigned TAG_W   = 24
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [INDEX_W-1:0] idx_i,
  input  logic [TAG_W-1:0]   tag_i,
  input  logic               inval_i,
  input  logic               wr_i,
  output logic               hit_o
);

  localparam int unsigned Lines = 2 ** INDEX_W;

  logic [Lines-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q [Lines];
  logic [TAG_W-1:0] tag_d [Lines];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    if (inval_i) begin
      valid_d[idx_i] = 1'b0;
    end
    if (wr_i) begin
      valid_d[idx_i] = 1'b1;
      tag_d[idx_i]   = tag_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    tag_q <= tag_d;
  end

  assign hit_o = valid_q[idx_i] && (tag_q[idx_i] == tag_i);

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through, no-write-allocate data cache controller: one CPU access at a
// time, word-serial refill on load miss, every store forwarded to memory.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned INDEX_W = 4,
  parameter int unsigned ADDR_W  = 32
) (
  input logic          clk,
  input logic          rst_n,
  dcache_ctrl_if.slave bus
);

  localparam int unsigned TAG_W = ADDR_W - INDEX_LSB - INDEX_W;
  localparam int unsigned LINES = 2 ** INDEX_W;

  dc_state_e         state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        k_q, k_d;
  logic [31:0]       data_q [LINES][WORDS_PER_LINE];
  logic [31:0]       data_d [LINES][WORDS_PER_LINE];

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   ltag;
  logic [1:0]         lword;
  logic               lookup_hit;
  logic               tag_inval;
  logic               tag_wr;

  assign idx   = INDEX_W'(addr_index(MAX_ADDR_W'(addr_q), INDEX_W));
  assign ltag  = TAG_W'(addr_tag(MAX_ADDR_W'(addr_q), INDEX_W));
  assign lword = addr_word(MAX_ADDR_W'(addr_q));

  dcache_tag_store #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_tag_store (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .idx_i   (idx),
    .tag_i   (ltag),
    .inval_i (tag_inval),
    .wr_i    (tag_wr),
    .hit_o   (lookup_hit)
  );

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    k_d       = k_q;
    data_d    = data_q;
    tag_inval = 1'b0;
    tag_wr    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.cpu_req) begin
          we_d    = bus.cpu_we;
          addr_d  = bus.cpu_addr;
          wdata_d = bus.cpu_wdata;
          state_d = StCompare;
        end
      end
      StCompare: begin
        if (we_q) begin
          // Store hit updates the line now; a store miss leaves the cache untouched.
          if (lookup_hit) begin
            data_d[idx][lword] = wdata_q;
          end
          state_d = StWriteMem;
        end else if (lookup_hit) begin
          state_d = StRespond;
        end else begin
          // Invalidate up front so an interrupted refill never exposes a partial line.
          k_d       = 2'd0;
          tag_inval = 1'b1;
          state_d   = StRefill;
        end
      end
      StRefill: begin
        if (bus.mem_ack) begin
          data_d[idx][k_q] = bus.mem_rdata;
          k_d              = k_q + 2'd1;
          if (k_q == 2'd3) begin
            tag_wr  = 1'b1;
            state_d = StRespond;
          end
        end
      end
      StWriteMem: begin
        if (bus.mem_ack) begin
          state_d = StRespond;
        end
      end
      StRespond: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      k_q     <= 2'd0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      k_q     <= k_d;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  always_comb begin
    bus.mem_addr = '0;
    if (state_q == StRefill) begin
      bus.mem_addr = {addr_q[ADDR_W-1:INDEX_LSB], k_q, 2'b00};
    end else if (state_q == StWriteMem) begin
      bus.mem_addr = {addr_q[ADDR_W-1:WORD_LSB], 2'b00};
    end
  end

  assign bus.cpu_ready = (state_q == StRespond);
  assign bus.hit       = (state_q == StCompare) && lookup_hit;
  assign bus.mem_req   = (state_q == StRefill) || (state_q == StWriteMem);
  assign bus.mem_we    = (state_q == StWriteMem);
  assign bus.mem_wdata = wdata_q;
  assign bus.word_sel  = lword;
  assign bus.line_w0   = data_q[idx][0];
  assign bus.line_w1   = data_q[idx][1];
  assign bus.line_w2   = data_q[idx][2];
  assign bus.line_w3   = data_q[idx][3];

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: a small memory responder answers mem_req with a
// configurable ack delay and logs every transfer; the 4:1 word mux is modelled here.
module tb_dcache_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dcache_ctrl_if #(.ADDR_W(32)) bus ();

  dcache_ctrl #(
    .INDEX_W (4),
    .ADDR_W  (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Refill data: 0xA0 + word, plus (line address - 1) in bits above 8.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return 32'hA0 + {30'd0, addr[3:2]} + (((addr >> 4) - 32'd1) << 8);
  endfunction

  function automatic logic [31:0] mux_out();
    case (bus.word_sel)
      2'd0:    return bus.line_w0;
      2'd1:    return bus.line_w1;
      2'd2:    return bus.line_w2;
      default: return bus.line_w3;
    endcase
  endfunction

  logic [31:0] log_addr [$];
  logic [31:0] log_wdata [$];
  logic        log_we [$];
  int          ack_wait   = 0;
  int          wait_cnt   = 0;
  int          addr_moves = 0;
  int          ready_cnt  = 0;
  logic [31:0] wait_addr;

  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
      end else if (rst_n && bus.mem_req) begin
        if (wait_cnt == 0) wait_addr = bus.mem_addr;
        else if (bus.mem_addr !== wait_addr) addr_moves++;
        if (wait_cnt < ack_wait) begin
          wait_cnt++;
        end else begin
          wait_cnt      = 0;
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = mem_word(bus.mem_addr);
          log_addr.push_back(bus.mem_addr);
          log_wdata.push_back(bus.mem_wdata);
          log_we.push_back(bus.mem_we);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus.cpu_ready) ready_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic cpu_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            output int cycles, output logic hit_obs, output logic [31:0] mid_word,
                            output logic [31:0] rdata);
    @(negedge clk);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    cycles   = 0;
    hit_obs  = 1'b0;
    mid_word = '0;
    do begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) hit_obs = bus.hit;
      if (cycles == 2) mid_word = mux_out();
    end while (!bus.cpu_ready && cycles < 400);
    rdata = mux_out();
    bus.cpu_req = 1'b0;
    if (!bus.cpu_ready) check_eq("cpu_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_refill(input string tag, input int base, input logic [31:0] line_addr);
    check_eq({tag, "_nacks"}, 32'(log_addr.size() - base), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (base + i < log_addr.size()) begin
        check_eq({tag, "_addr"}, log_addr[base+i], line_addr + 32'(4 * i));
        check_eq({tag, "_we"}, 32'(log_we[base+i]), 32'd0);
      end
    end
  endtask

  initial begin
    int          cyc;
    int          n0;
    int          r0;
    logic        h;
    logic [31:0] mid;
    logic [31:0] rd;

    rst_n         = 1'b0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_cpu_ready", 32'(bus.cpu_ready), 32'd0);
    check_eq("rst_hit", 32'(bus.hit), 32'd0);
    check_eq("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check_eq("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check_eq("rst_mem_addr", bus.mem_addr, 32'd0);
    check_eq("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check_eq("rst_word_sel", 32'(bus.word_sel), 32'd0);
    rst_n = 1'b1;

    // Cold load miss: full refill of line 0x10.
    n0 = log_addr.size();
    r0 = ready_cnt;
    cpu_access(1'b0, 32'h0000_0010, '0, cyc, h, mid, rd);
    check_eq("t1_hit", 32'(h), 32'd0);
    check_eq("t1_latency", 32'(cyc), 32'd9);
    check_eq("t1_rdata", rd, 32'hA0);
    check_eq("t1_w0", bus.line_w0, 32'hA0);
    check_eq("t1_w1", bus.line_w1, 32'hA1);
    check_eq("t1_w2", bus.line_w2, 32'hA2);
    check_eq("t1_w3", bus.line_w3, 32'hA3);
    check_eq("t1_word_sel", 32'(bus.word_sel), 32'd0);
    repeat (2) @(negedge clk);
    check_eq("t1_ready_pulses", 32'(ready_cnt - r0), 32'd1);
    check_refill("t1", n0, 32'h10);

    // Load hit, last word.
    n0 = log_addr.size();
    cpu_access(1'b0, 32'h0000_001C, '0, cyc, h, mid, rd);
    check_eq("t2_hit", 32'(h), 32'd1);
    check_eq("t2_latency", 32'(cyc), 32'd2);
    check_eq("t2_word_sel", 32'(bus.word_sel), 32'd3);
    check_eq("t2_rdata", rd, 32'hA3);
    check_eq("t2_no_mem", 32'(log_addr.size() - n0), 32'd0);

    // Store hit: line updated before the memory ack, then written through.
    n0 = log_addr.size();
    cpu_access(1'b1, 32'h0000_0018, 32'hDEAD_BEEF, cyc, h, mid, rd);
    check_eq("t3_hit", 32'(h), 32'd1);
    check_eq("t3_early_update", mid, 32'hDEAD_BEEF);
    check_eq("t3_latency", 32'(cyc), 32'd3);
    check_eq("t3_nwrites", 32'(log_addr.size() - n0), 32'd1);
    if (log_addr.size() > n0) begin
      check_eq("t3_addr", log_addr[n0], 32'h18);
      check_eq("t3_we", 32'(log_we[n0]), 32'd1);
      check_eq("t3_wdata", log_wdata[n0], 32'hDEAD_BEEF);
    end
    cpu_access(1'b0, 32'h0000_0018, '0, cyc, h, mid, rd);
    check_eq("t3_load_hit", 32'(h), 32'd1);
    check_eq("t3_load_rdata", rd, 32'hDEAD_BEEF);

    // Store miss to an aliasing tag: memory write only, no allocation.
    n0 = log_addr.size();
    cpu_access(1'b1, 32'h0000_1010, 32'h1234_5678, cyc, h, mid, rd);
    check_eq("t4_hit", 32'(h), 32'd0);
    check_eq("t4_nwrites", 32'(log_addr.size() - n0), 32'd1);
    if (log_addr.size() > n0) begin
      check_eq("t4_addr", log_addr[n0], 32'h1010);
      check_eq("t4_wdata", log_wdata[n0], 32'h1234_5678);
    end
    cpu_access(1'b0, 32'h0000_0010, '0, cyc, h, mid, rd);
    check_eq("t4_old_hit", 32'(h), 32'd1);
    check_eq("t4_old_rdata", rd, 32'hA0);
    n0 = log_addr.size();
    cpu_access(1'b0, 32'h0000_1010, '0, cyc, h, mid, rd);
    check_eq("t4_new_hit", 32'(h), 32'd0);
    check_eq("t4_new_rdata", rd, 32'h0001_00A0);
    check_eq("t4_new_w3", bus.line_w3, 32'h0001_00A3);
    check_refill("t4", n0, 32'h1010);

    // Highest index line.
    cpu_access(1'b0, 32'h0000_00F8, '0, cyc, h, mid, rd);
    check_eq("t5_miss", 32'(h), 32'd0);
    check_eq("t5_rdata", rd, 32'hEA2);
    cpu_access(1'b0, 32'h0000_00FC, '0, cyc, h, mid, rd);
    check_eq("t5_hit", 32'(h), 32'd1);
    check_eq("t5_hit_rdata", rd, 32'hEA3);

    // Reset after the second refill ack of line 0x20.
    n0 = log_addr.size();
    @(negedge clk);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'h0000_0020;
    cyc = 0;
    while (log_addr.size() < n0 + 2 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("t6_two_acks", 32'(log_addr.size() >= n0 + 2), 32'd1);
    @(negedge clk);
    rst_n       = 1'b0;
    bus.cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("t6_rst_mem_req", 32'(bus.mem_req), 32'd0);
    check_eq("t6_rst_ready", 32'(bus.cpu_ready), 32'd0);
    rst_n = 1'b1;
    n0 = log_addr.size();
    r0 = ready_cnt;
    cpu_access(1'b0, 32'h0000_0020, '0, cyc, h, mid, rd);
    check_eq("t6_hit", 32'(h), 32'd0);
    check_eq("t6_latency", 32'(cyc), 32'd9);
    check_eq("t6_rdata", rd, 32'h1A0);
    check_eq("t6_w3", bus.line_w3, 32'h1A3);
    repeat (2) @(negedge clk);
    check_eq("t6_ready_pulses", 32'(ready_cnt - r0), 32'd1);
    check_refill("t6", n0, 32'h20);
    // Old line 0x10 still has a matching tag but its valid bit was reset.
    cpu_access(1'b0, 32'h0000_0010, '0, cyc, h, mid, rd);
    check_eq("t6_invalid_miss", 32'(h), 32'd0);
    check_eq("t6_refetch", rd, 32'hA0);

    // Slow memory: five wait cycles before every ack.
    ack_wait   = 5;
    addr_moves = 0;
    n0 = log_addr.size();
    r0 = ready_cnt;
    cpu_access(1'b0, 32'h0000_0034, '0, cyc, h, mid, rd);
    check_eq("t7_hit", 32'(h), 32'd0);
    check_eq("t7_latency", 32'(cyc), 32'd29);
    check_eq("t7_rdata", rd, 32'h2A1);
    check_eq("t7_w0", bus.line_w0, 32'h2A0);
    check_eq("t7_w3", bus.line_w3, 32'h2A3);
    repeat (2) @(negedge clk);
    check_eq("t7_addr_stable", 32'(addr_moves), 32'd0);
    check_eq("t7_ready_pulses", 32'(ready_cnt - r0), 32'd1);
    check_refill("t7", n0, 32'h30);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
